// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO (valid/ready in, LSB-first serial out) -- rev 1.0

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10_416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              reset,
  input  logic                              i_Tx_DV,
  input  logic [7:0]                        i_Tx_Byte,
  output logic                              o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count,
  output logic                              o_Tx_Serial,
  output logic                              o_Tx_Active,
  output logic                              o_Tx_Done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(CLKS_PER_BIT);
  localparam logic [KW-1:0] BIT_LAST = KW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  state_t        state;
  logic [KW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign push = i_Tx_DV && o_Tx_Ready;
  assign pop  = (state == IDLE) && (o_Fifo_Count != '0);

  always_comb begin
    count_next = o_Fifo_Count;
    if (push && !pop)
      count_next = o_Fifo_Count + CW'(1);
    else if (pop && !push)
      count_next = o_Fifo_Count - CW'(1);
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge i_Clock) begin
    if (push)
      mem[wr_ptr] <= i_Tx_Byte;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_Fifo_Count <= '0;
      o_Tx_Ready   <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      o_Fifo_Count <= count_next;
      o_Tx_Ready   <= (count_next != FULL);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          if (pop) begin
            shift       <= mem[rd_ptr];
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Serial <= shift[0];
            state       <= DATA;
          end else begin
            clk_cnt <= clk_cnt + KW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            // The shift register always presents the current bit at [0].
            if (bit_idx != 3'd7) begin
              bit_idx     <= bit_idx + 3'd1;
              shift       <= {1'b0, shift[7:1]};
              o_Tx_Serial <= shift[1];
            end else begin
              bit_idx     <= '0;
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + KW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            state       <= CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + KW'(1);
          end
        end
        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
